// File: rtl/dds_reg_writer.sv
// SPI register writer/reader for a DDS: instruction byte, 1..8 payload bytes, then io_update.
// Optional readback path is enabled by defining DDS_READBACK_EN.
module dds_reg_writer #(
    parameter int GAP_CYCLES  = 2,
    parameter int IOUP_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        wr_rd,
    input  logic [4:0]  wr_addr,
    input  logic [3:0]  wr_len,
    input  logic [63:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] rd_data,
    output logic        io_update,
    output logic        spi_start,
    output logic [7:0]  spi_in,
    input  logic [7:0]  spi_out,
    input  logic        spi_cs
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES)
                           ? ((TIMEOUT > IOUP_CYCLES) ? TIMEOUT : IOUP_CYCLES)
                           : ((GAP_CYCLES > IOUP_CYCLES) ? GAP_CYCLES : IOUP_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_GAP,
        S_IOUP,
        S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;
    logic        r_rd;
    logic        r_err;
    logic        r_rej;
    logic [7:0]  r_spi_in;
    logic [63:0] r_shift;

    logic        w_len_ok;
    logic        w_req_ok;
    logic        w_accept;
    logic        w_reject;
    logic        w_byte_done;
    logic        w_last;
    logic        w_tmo;
    logic        w_tmo_hit;

    assign w_len_ok = (wr_len != 4'd0) && (wr_len <= 4'd8);
`ifdef DDS_READBACK_EN
    assign w_req_ok = w_len_ok;
`else
    assign w_req_ok = w_len_ok && !wr_rd;
`endif
    assign w_accept    = (r_state == S_IDLE) && wr_req && w_req_ok;
    assign w_reject    = (r_state == S_IDLE) && wr_req && !w_req_ok;
    assign w_byte_done = (r_state == S_WAIT_HIGH) && spi_cs;
    assign w_last      = (r_idx == r_len);
    assign w_tmo       = (r_cnt == CW'(TIMEOUT - 1));
    assign w_tmo_hit   = w_tmo && (((r_state == S_WAIT_LOW) && spi_cs) ||
                                   ((r_state == S_WAIT_HIGH) && !spi_cs));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_accept) w_next = S_START;
            S_START:     w_next = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!spi_cs)    w_next = S_WAIT_HIGH;
                else if (w_tmo) w_next = S_FIN;
            end
            S_WAIT_HIGH: begin
                if (spi_cs) begin
                    if (w_last)               w_next = r_rd ? S_FIN : S_IOUP;
                    else if (GAP_CYCLES == 0) w_next = S_START;
                    else                      w_next = S_GAP;
                end else if (w_tmo) begin
                    w_next = S_FIN;
                end
            end
            S_GAP:       if (r_cnt == CW'(GAP_CYCLES - 1))  w_next = S_START;
            S_IOUP:      if (r_cnt == CW'(IOUP_CYCLES - 1)) w_next = S_FIN;
            S_FIN:       w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // busy falls in the same cycle done rises; a rejected request never raises busy
    always_comb begin
        busy      = (r_state != S_IDLE) && (r_state != S_FIN);
        done      = (r_state == S_FIN) || r_rej;
        err       = ((r_state == S_FIN) && r_err) || r_rej;
        spi_start = (r_state == S_START);
        io_update = (r_state == S_IOUP);
    end

    // One counter serves gap, io_update width and the per-edge timeout; it restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst || (w_next != r_state)) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH) ||
                     (r_state == S_GAP) || (r_state == S_IOUP)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rej    <= 1'b0;
            r_err    <= 1'b0;
            r_rd     <= 1'b0;
            r_len    <= 4'd0;
            r_idx    <= 4'd0;
            r_spi_in <= 8'd0;
        end else begin
            r_rej <= w_reject;
            if (w_accept) begin
                r_err    <= 1'b0;
                r_rd     <= wr_rd;
                r_len    <= wr_len;
                r_idx    <= 4'd0;
                r_spi_in <= {wr_rd, 2'b00, wr_addr};
            end
            if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
            if (w_byte_done && !w_last) begin
                r_idx    <= r_idx + 4'd1;
                r_spi_in <= r_shift[63:56];
            end
        end
    end

    // Payload is left-aligned on accept so the next byte to send is always the top byte
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shift <= wr_data << {(4'd8 - wr_len), 3'b000};
        end else if (w_byte_done && !w_last) begin
            r_shift <= {r_shift[55:0], 8'h00};
        end
    end

    assign spi_in = r_spi_in;

`ifdef DDS_READBACK_EN
    logic [63:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (w_accept && wr_rd) begin
            r_rd_data <= '0;
        end else if (w_byte_done && r_rd && (r_idx != 4'd0)) begin
            r_rd_data <= {r_rd_data[55:0], spi_out};
        end
    end

    assign rd_data = r_rd_data;
`else
    logic [7:0] w_unused_spi_out;

    assign w_unused_spi_out = spi_out;
    assign rd_data          = '0;
`endif

endmodule

// File: tb/tb_dds_reg_writer.sv
// Bench for dds_reg_writer: behavioural SPI byte engine, byte-list reference model, directed and random transactions.
module tb_dds_reg_writer;
    localparam int GAP  = 2;
    localparam int IOUP = 4;
    localparam int TMO  = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_req = 1'b0;
    logic        wr_rd = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [3:0]  wr_len = '0;
    logic [63:0] wr_data = '0;
    logic        busy, done, err, io_update, spi_start;
    logic [63:0] rd_data;
    logic [7:0]  spi_in;
    logic [7:0]  spi_out;
    logic        spi_cs;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit         eng_on = 1'b1;
    bit         eng_busy = 1'b0;
    int         stable_err = 0;
    logic [7:0] resp_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] resp_log[$];

    int done_cnt = 0, done_cyc = 0, start_cnt = 0, start_cyc = 0;
    int ioup_cnt = 0, ioup_rise = 0, ioup_rise_sent = 0, ioup_last_cyc = 0;
    logic done_err = 1'b0;
    logic ioup_prev = 1'b0;

    dds_reg_writer #(.GAP_CYCLES(GAP), .IOUP_CYCLES(IOUP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_rd(wr_rd), .wr_addr(wr_addr),
        .wr_len(wr_len), .wr_data(wr_data), .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .io_update(io_update), .spi_start(spi_start),
        .spi_in(spi_in), .spi_out(spi_out), .spi_cs(spi_cs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_err = err;
            done_cyc = cyc;
        end
        if (spi_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (io_update) begin
            ioup_cnt = ioup_cnt + 1;
            ioup_last_cyc = cyc;
            if (!ioup_prev) begin
                ioup_rise = ioup_rise + 1;
                ioup_rise_sent = sent_q.size();
            end
        end
        ioup_prev = io_update;
    end

    // SPI byte engine: after spi_start, drops cs, shifts for a few cycles, returns a byte at cs rise
    initial begin : engine
        logic [7:0] b;
        logic [7:0] r;
        spi_cs  = 1'b1;
        spi_out = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start && eng_on) begin
                eng_busy = 1'b1;
                b = spi_in;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                spi_cs = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else r = 8'($urandom);
                if (spi_in !== b) stable_err = stable_err + 1;
                sent_q.push_back(b);
                resp_log.push_back(r);
                spi_out = r;
                spi_cs = 1'b1;
                eng_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic rd, input logic [4:0] addr, input int len,
                                            input logic [63:0] data, input int i);
        if (i == 0) return {rd, 2'b00, addr};
        return 8'((data >> (8 * (len - i))) & 64'hFF);
    endfunction

    task automatic wait_done(input int base, input int limit);
        int waited = 0;
        while (done_cnt == base && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_txn(input logic rd, input logic [4:0] addr, input int len,
                           input logic [63:0] data, input bit poke);
        int b_done = done_cnt;
        int b_sent = sent_q.size();
        int b_ioup = ioup_cnt;
        int b_rise = ioup_rise;
        int b_start = start_cnt;
        int b_stab = stable_err;
        logic [63:0] prev_rd = rd_data;
        logic [63:0] exp_rd = '0;
        logic [7:0] obs_b;
        @(negedge clk);
        wr_req = 1'b1; wr_rd = rd; wr_addr = addr; wr_len = 4'(len); wr_data = data;
        @(negedge clk);
        wr_req = 1'b0;
        chk("busy_after_req", 64'(busy), 64'd1);
        if (poke) begin
            repeat (10) @(negedge clk);
            wr_req = 1'b1; wr_rd = ~rd; wr_addr = ~addr; wr_len = 4'd1; wr_data = ~data;
            @(negedge clk);
            wr_req = 1'b0;
        end
        wait_done(b_done, 5000);
        chk("done_pulses", 64'(done_cnt - b_done), 64'd1);
        chk("done_err", 64'(done_err), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
        chk("spi_starts", 64'(start_cnt - b_start), 64'(len + 1));
        chk("bytes_sent", 64'(sent_q.size() - b_sent), 64'(len + 1));
        chk("spi_in_stable", 64'(stable_err - b_stab), 64'd0);
        for (int i = 0; i <= len; i++) begin
            obs_b = (b_sent + i < sent_q.size()) ? sent_q[b_sent + i] : 8'hXX;
            chk($sformatf("byte%0d", i), 64'(obs_b), 64'(exp_byte(rd, addr, len, data, i)));
        end
        if (!rd) begin
            chk("ioup_width", 64'(ioup_cnt - b_ioup), 64'(IOUP));
            chk("ioup_single", 64'(ioup_rise - b_rise), 64'd1);
            chk("ioup_after_last", 64'(ioup_rise_sent), 64'(b_sent + len + 1));
            chk("done_after_ioup", 64'(done_cyc > ioup_last_cyc), 64'd1);
            chk("rd_data_kept", rd_data, prev_rd);
        end else begin
            for (int i = 1; i <= len; i++) begin
                if (b_sent + i < resp_log.size()) exp_rd = (exp_rd << 8) | 64'(resp_log[b_sent + i]);
            end
            chk("read_no_ioup", 64'(ioup_cnt - b_ioup), 64'd0);
            chk("rd_data", rd_data, exp_rd);
        end
    endtask

    task automatic chk_reject(input logic rd, input logic [4:0] addr, input int len);
        int b_start = start_cnt;
        @(negedge clk);
        wr_req = 1'b1; wr_rd = rd; wr_addr = addr; wr_len = 4'(len); wr_data = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        wr_req = 1'b0;
        chk($sformatf("rej%0d_done", len), 64'(done), 64'd1);
        chk($sformatf("rej%0d_err", len), 64'(err), 64'd1);
        chk($sformatf("rej%0d_busy", len), 64'(busy), 64'd0);
        @(negedge clk);
        chk($sformatf("rej%0d_done_drop", len), 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        chk($sformatf("rej%0d_no_start", len), 64'(start_cnt - b_start), 64'd0);
    endtask

    initial begin : main
        int b_done, b_start, b_ioup, waited;
        logic rd;
        int len;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ioup", 64'(io_update), 64'd0);
        chk("rst_spi_start", 64'(spi_start), 64'd0);
        chk("rst_spi_in", 64'(spi_in), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 5'h0E, 8, 64'h1234_5678_9ABC_DEF0, 1'b0);

`ifdef DDS_READBACK_EN
        resp_q.push_back(8'hAB);
        resp_q.push_back(8'hCD);
        run_txn(1'b1, 5'h07, 2, 64'h0, 1'b0);
        chk("read_abcd", rd_data, 64'h0000_0000_0000_ABCD);
`else
        chk_reject(1'b1, 5'h07, 2);
        chk("read_disabled_rd_data", rd_data, 64'd0);
`endif

        chk_reject(1'b0, 5'h03, 0);
        chk_reject(1'b0, 5'h03, 9);

        for (int t = 0; t < 6; t++) begin
`ifdef DDS_READBACK_EN
            rd = 1'($urandom_range(0, 1));
`else
            rd = 1'b0;
`endif
            len = $urandom_range(1, 8);
            run_txn(rd, 5'($urandom), len, {$urandom, $urandom}, 1'b0);
        end

        run_txn(1'b0, 5'h11, 8, {$urandom, $urandom}, 1'b1);

        // Timeout: engine ignores spi_start so spi_cs never falls
        eng_on = 1'b0;
        b_done = done_cnt; b_start = start_cnt; b_ioup = ioup_cnt;
        @(negedge clk);
        wr_req = 1'b1; wr_rd = 1'b0; wr_addr = 5'h02; wr_len = 4'd4; wr_data = 64'hDEAD_BEEF;
        @(negedge clk);
        wr_req = 1'b0;
        wait_done(b_done, 1000);
        chk("tmo_done_pulses", 64'(done_cnt - b_done), 64'd1);
        chk("tmo_err", 64'(done_err), 64'd1);
        chk("tmo_latency", 64'(done_cyc - (start_cyc + 1)), 64'(TMO));
        chk("tmo_starts", 64'(start_cnt - b_start), 64'd1);
        chk("tmo_no_ioup", 64'(ioup_cnt - b_ioup), 64'd0);
        chk("tmo_busy", 64'(busy), 64'd0);
        eng_on = 1'b1;

        // Reset while the third byte is in flight
        b_done = done_cnt; b_start = start_cnt;
        @(negedge clk);
        wr_req = 1'b1; wr_rd = 1'b0; wr_addr = 5'h0A; wr_len = 4'd8; wr_data = {$urandom, $urandom};
        @(negedge clk);
        wr_req = 1'b0;
        waited = 0;
        while (start_cnt - b_start < 3 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_reached_byte3", 64'(start_cnt - b_start >= 3), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_spi_start", 64'(spi_start), 64'd0);
        chk("mid_rst_spi_in", 64'(spi_in), 64'd0);
        chk("mid_rst_ioup", 64'(io_update), 64'd0);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt - b_done), 64'd0);
        waited = 0;
        while (eng_busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        run_txn(1'b0, 5'h15, 3, 64'h0000_0000_00A1_B2C3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
